// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results, or waits for load data, aligns and extends it, and drives the register-file write port.
// Optional macro WB_INSTRET_EN adds a 32-bit retired-instruction counter output (instret).
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      write_addr,
    output logic [XLEN-1:0] write_data,
    output logic            write_enable,
    output logic            load_err,
`ifdef WB_INSTRET_EN
    output logic [31:0]     instret,
`endif
    output logic            busy
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      state_reg;
    logic [4:0]  rd_reg;
    logic        reg_write_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;

    logic [7:0]      byte_lane [4];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            load_ok;
    logic            accept_alu;
    logic            accept_load;
    logic            load_done;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign in_ready    = (state_reg == IDLE);
    assign busy        = (state_reg == LOAD_WAIT);
    assign accept_alu  = in_ready && in_valid && !in_is_load;
    assign accept_load = in_ready && in_valid && in_is_load;
    assign load_done   = (state_reg == LOAD_WAIT) && mem_rvalid;

    assign byte_sel = byte_lane[addr_lo_reg];
    assign half_sel = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Alignment and legality of the pending load, evaluated against the returning word.
    always_comb begin
        load_data = '0;
        load_ok   = 1'b0;
        case (funct3_reg)
            3'b000: begin
                load_data = {{24{byte_sel[7]}}, byte_sel};
                load_ok   = 1'b1;
            end
            3'b001: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                load_ok   = !addr_lo_reg[0];
            end
            3'b010: begin
                load_data = mem_rdata;
                load_ok   = (addr_lo_reg == 2'b00);
            end
            3'b100: begin
                load_data = {24'd0, byte_sel};
                load_ok   = 1'b1;
            end
            3'b101: begin
                load_data = {16'd0, half_sel};
                load_ok   = !addr_lo_reg[0];
            end
            default: begin
                load_data = '0;
                load_ok   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            funct3_reg    <= '0;
            addr_lo_reg   <= '0;
            write_addr    <= '0;
            write_data    <= '0;
            write_enable  <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            load_err     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept_load) begin
                        rd_reg        <= in_rd;
                        reg_write_reg <= in_reg_write;
                        funct3_reg    <= in_funct3;
                        addr_lo_reg   <= in_addr_lo;
                        state_reg     <= LOAD_WAIT;
                    end else if (accept_alu && in_reg_write && (in_rd != 5'd0)) begin
                        write_enable <= 1'b1;
                        write_addr   <= in_rd;
                        write_data   <= in_alu_result;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                        if (!load_ok) begin
                            load_err <= 1'b1;
                        end else if (reg_write_reg && (rd_reg != 5'd0)) begin
                            write_enable <= 1'b1;
                            write_addr   <= rd_reg;
                            write_data   <= load_data;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    // Counts every retirement, including suppressed and faulting writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (accept_alu || load_done) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage: driver pushes expected commits, a negedge monitor checks every cycle.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [31:0] in_alu_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic        load_err;
    logic        busy;
`ifdef WB_INSTRET_EN
    logic [31:0] instret;
`endif

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .in_alu_result(in_alu_result),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .load_err     (load_err),
`ifdef WB_INSTRET_EN
        .instret      (instret),
`endif
        .busy         (busy)
    );

    typedef struct {
        int          due;
        logic        we;
        logic        err;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          neg_cnt = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] exp_instret = '0;

    // Reference load semantics: pick the addressed byte/halfword arithmetically, then extend.
    task automatic model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rdata,
                              output logic ok, output logic [31:0] v);
        logic [31:0] b;
        logic [31:0] h;
        b  = (rdata >> (8 * int'(lo))) & 32'hFF;
        h  = (rdata >> (16 * int'(lo[1]))) & 32'hFFFF;
        ok = 1'b0;
        v  = '0;
        case (f3)
            3'd0: begin ok = 1'b1;            v = (b >= 128)   ? b + 32'hFFFFFF00 : b; end
            3'd1: begin ok = (lo % 2 == 0);   v = (h >= 32768) ? h + 32'hFFFF0000 : h; end
            3'd2: begin ok = (lo == 0);       v = rdata; end
            3'd4: begin ok = 1'b1;            v = b; end
            3'd5: begin ok = (lo % 2 == 0);   v = h; end
            default: ok = 1'b0;
        endcase
    endtask

    task automatic push(input logic we, input logic err, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.due = neg_cnt + 1;
        e.we = we;
        e.err = err;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic check_ready(input string tag, input logic exp_ready);
        checks++;
        if (in_ready !== exp_ready || busy !== !exp_ready) begin
            errors++;
            $display("FAIL %s: in_ready=%b busy=%b, expected in_ready=%b busy=%b",
                     tag, in_ready, busy, exp_ready, !exp_ready);
        end
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic rw, input logic [31:0] v, input logic junk_rvalid);
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_reg_write = rw; in_alu_result = v;
        in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
        mem_rvalid = junk_rvalid; mem_rdata = $urandom;
        check_ready("alu_ready", 1'b1);
        @(posedge clk);
        push(rw && rd != 0, 1'b0, rd, v);
        $display("ALU  rd=%0d rw=%b data=%08h", rd, rw, v);
    endtask

    task automatic send_load(input logic [4:0] rd, input logic rw, input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] rdata, input int wait_cycles);
        logic        ok;
        logic [31:0] v;
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_reg_write = rw;
        in_funct3 = f3; in_addr_lo = lo; in_alu_result = $urandom; mem_rvalid = 1'b0;
        check_ready("load_ready", 1'b1);
        @(posedge clk);
        for (int i = 0; i <= wait_cycles; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); in_is_load = 1'($urandom); in_rd = 5'($urandom);
            in_reg_write = 1'b1; in_alu_result = $urandom;
            check_ready("load_wait", 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        check_ready("load_rvalid", 1'b0);
        @(posedge clk);
        model_load(f3, lo, rdata, ok, v);
        push(ok && rw && rd != 0, !ok, rd, v);
        $display("LOAD rd=%0d rw=%b f3=%0d lo=%0d rdata=%08h ok=%b data=%08h", rd, rw, f3, lo, rdata, ok, v);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0; mem_rvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic e_we;
        logic e_err;
        exp_t e;
        neg_cnt++;
        if (reset) begin
            e_we = 1'b0;
            e_err = 1'b0;
            if (q.size() > 0 && q[0].due == neg_cnt) begin
                e = q.pop_front();
                e_we = e.we;
                e_err = e.err;
                if (e.we) begin
                    last_addr = e.addr;
                    last_data = e.data;
                end
                exp_instret++;
            end
            checks++;
            if (write_enable !== e_we || load_err !== e_err) begin
                errors++;
                $display("FAIL strobe cycle %0d: write_enable=%b load_err=%b, expected %b %b",
                         neg_cnt, write_enable, load_err, e_we, e_err);
            end
            checks++;
            if (write_addr !== last_addr || write_data !== last_data) begin
                errors++;
                $display("FAIL port cycle %0d: addr=%0d data=%08h, expected addr=%0d data=%08h",
                         neg_cnt, write_addr, write_data, last_addr, last_data);
            end
`ifdef WB_INSTRET_EN
            checks++;
            if (instret !== exp_instret) begin
                errors++;
                $display("FAIL instret cycle %0d: got %0d, expected %0d", neg_cnt, instret, exp_instret);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_alu_result = '0;
        in_is_load = 1'b0; in_funct3 = '0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0 || load_err !== 1'b0
            || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: we=%b addr=%0d data=%08h err=%b busy=%b ready=%b, expected 0 0 0 0 0 1",
                     write_enable, write_addr, write_data, load_err, busy, in_ready);
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Directed cases first: the first one lands on the first edge after reset release.
        send_alu(5'd5, 1'b1, 32'h12345678, 1'b0);
        send_alu(5'd9, 1'b1, 32'hCAFEF00D, 1'b1);
        send_alu(5'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        send_alu(5'd3, 1'b0, 32'h55555555, 1'b1);
        send_load(5'd7, 1'b1, 3'b000, 2'd2, 32'h00800000, 0);
        send_load(5'd8, 1'b1, 3'b100, 2'd2, 32'h00800000, 1);
        send_load(5'd10, 1'b1, 3'b101, 2'd2, 32'h8001ABCD, 2);
        send_load(5'd11, 1'b1, 3'b001, 2'd0, 32'h12348765, 0);
        send_load(5'd12, 1'b1, 3'b010, 2'd1, 32'h11111111, 0);
        send_load(5'd13, 1'b1, 3'b011, 2'd0, 32'h22222222, 1);
        send_load(5'd14, 1'b1, 3'b101, 2'd3, 32'h33333333, 0);
        send_load(5'd0, 1'b1, 3'b010, 2'd0, 32'h44444444, 0);
        send_load(5'd15, 1'b1, 3'b010, 2'd0, 32'h89ABCDEF, 0);
        go_idle();
        repeat (2) @(negedge clk);

        // Reset while a load is outstanding: the later response must be dropped.
        send_alu(5'd20, 1'b1, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd21; in_reg_write = 1'b1;
        in_funct3 = 3'b010; in_addr_lo = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        q.delete();
        last_addr = '0; last_data = '0; exp_instret = '0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b addr=%0d data=%08h err=%b, expected all zero",
                     write_enable, write_addr, write_data, load_err);
        end
        check_ready("reset_ready", 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_ready("after_reset_rvalid", 1'b1);
        $display("RESET during LOAD_WAIT, stray mem_rvalid issued");
        repeat (2) @(negedge clk);

        // Randomized mix of ALU ops and loads of every funct3/offset.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                send_alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom,
                         1'($urandom));
            end else begin
                send_load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                          2'($urandom), $urandom, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 4) == 0) go_idle();
        end
        go_idle();
        repeat (4) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expected commits never observed, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
